// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - ISA encodings, ALU ops and pipeline register types for the cpu core
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifex_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } exmw_t;

  localparam ifex_t IFEX_BUBBLE = '{pc: 32'h0, instr: NOP};
  localparam exmw_t EXMW_BUBBLE = '0;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU; zero flag drives beq/bne resolution
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  input  alu_op_t     i_alu_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {31'h0, $signed(i_a) < $signed(i_b)};
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_LUI: o_result = {i_b[15:0], 16'h0};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'h0);

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - 3-stage MIPS-subset core (IF | EX | MW) showing one byte of $2
// Build option DISPLAY_PC_EN: control 2'b11 shows PC[9:2] instead of $2[31:24].
module cpu
  import cpu_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] control,
  output logic [7:0] register
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_dmem [DMEM_DEPTH];
  logic [31:0] r_gpr  [32];
  logic [31:0] r_pc;
  ifex_t       r_ifex;
  exmw_t       r_exmw;

  logic [31:0]    w_fetch, w_load_data, w_mw_result;
  logic [5:0]     w_op, w_funct;
  logic [4:0]     w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [31:0]    w_sext, w_zext, w_rs_val, w_rt_val, w_alu_b, w_alu_res;
  logic [31:0]    w_pc4, w_br_target, w_j_target;
  alu_op_t        w_alu_op;
  logic           w_use_imm, w_zext_sel, w_reg_we, w_mem_re, w_mem_we;
  logic           w_is_beq, w_is_bne, w_is_j, w_zero, w_taken, w_gpr_we;
  logic [DAW-1:0] w_dmem_addr;

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] = NOP;
  end

  assign w_fetch = r_imem[r_pc[IAW+1:2]];

  assign w_op    = r_ifex.instr[31:26];
  assign w_rs    = r_ifex.instr[25:21];
  assign w_rt    = r_ifex.instr[20:16];
  assign w_rd    = r_ifex.instr[15:11];
  assign w_shamt = r_ifex.instr[10:6];
  assign w_funct = r_ifex.instr[5:0];
  assign w_sext  = {{16{r_ifex.instr[15]}}, r_ifex.instr[15:0]};
  assign w_zext  = {16'h0, r_ifex.instr[15:0]};

  assign w_dmem_addr = r_exmw.alu_res[DAW+1:2];
  assign w_load_data = r_dmem[w_dmem_addr];
  assign w_mw_result = r_exmw.mem_re ? w_load_data : r_exmw.alu_res;
  assign w_gpr_we    = r_exmw.reg_we && (r_exmw.rd != 5'd0);

  // The MW result bypasses the register file for the instruction right behind it.
  assign w_rs_val = (w_gpr_we && r_exmw.rd == w_rs) ? w_mw_result : r_gpr[w_rs];
  assign w_rt_val = (w_gpr_we && r_exmw.rd == w_rt) ? w_mw_result : r_gpr[w_rt];

  always_comb begin
    w_alu_op   = ALU_ADD;
    w_use_imm  = 1'b0;
    w_zext_sel = 1'b0;
    w_reg_we   = 1'b0;
    w_dest     = w_rt;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    w_is_j     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dest   = w_rd;
        w_reg_we = 1'b1;
        case (w_funct)
          F_ADD:   w_alu_op = ALU_ADD;
          F_SUB:   w_alu_op = ALU_SUB;
          F_AND:   w_alu_op = ALU_AND;
          F_OR:    w_alu_op = ALU_OR;
          F_SLT:   w_alu_op = ALU_SLT;
          F_SLL:   w_alu_op = ALU_SLL;
          default: w_reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin w_use_imm = 1'b1; w_reg_we = 1'b1; end
      OP_ANDI: begin w_use_imm = 1'b1; w_zext_sel = 1'b1; w_reg_we = 1'b1; w_alu_op = ALU_AND; end
      OP_ORI:  begin w_use_imm = 1'b1; w_zext_sel = 1'b1; w_reg_we = 1'b1; w_alu_op = ALU_OR; end
      OP_LUI:  begin w_use_imm = 1'b1; w_zext_sel = 1'b1; w_reg_we = 1'b1; w_alu_op = ALU_LUI; end
      OP_LW:   begin w_use_imm = 1'b1; w_reg_we = 1'b1; w_mem_re = 1'b1; end
      OP_SW:   begin w_use_imm = 1'b1; w_mem_we = 1'b1; end
      OP_BEQ:  begin w_alu_op = ALU_SUB; w_is_beq = 1'b1; end
      OP_BNE:  begin w_alu_op = ALU_SUB; w_is_bne = 1'b1; end
      OP_J:    w_is_j = 1'b1;
      default: ;
    endcase
  end

  assign w_alu_b = w_use_imm ? (w_zext_sel ? w_zext : w_sext) : w_rt_val;

  cpu_alu u_alu (
    .i_a      (w_rs_val),
    .i_b      (w_alu_b),
    .i_shamt  (w_shamt),
    .i_alu_op (w_alu_op),
    .o_result (w_alu_res),
    .o_zero   (w_zero)
  );

  assign w_pc4       = r_ifex.pc + 32'd4;
  assign w_br_target = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc4[31:28], r_ifex.instr[25:0], 2'b00};
  assign w_taken     = w_is_j || (w_is_beq && w_zero) || (w_is_bne && !w_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_ifex <= IFEX_BUBBLE;
      r_exmw <= EXMW_BUBBLE;
    end else begin
      if (w_taken) begin
        r_pc   <= w_is_j ? w_j_target : w_br_target;
        r_ifex <= IFEX_BUBBLE;
      end else begin
        r_pc   <= r_pc + 32'd4;
        r_ifex <= '{pc: r_pc, instr: w_fetch};
      end
      r_exmw <= '{reg_we: w_reg_we, rd: w_dest, mem_re: w_mem_re, mem_we: w_mem_we,
                  alu_res: w_alu_res, store_data: w_rt_val};
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_gpr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_gpr[g] <= '0;
      else if (w_gpr_we && r_exmw.rd == 5'(g)) r_gpr[g] <= w_mw_result;
    end
  end

  for (genvar g = 0; g < DMEM_DEPTH; g++) begin : g_dmem
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_dmem[g] <= '0;
      else if (r_exmw.mem_we && w_dmem_addr == DAW'(g)) r_dmem[g] <= r_exmw.store_data;
    end
  end

  always_comb begin
    register = 8'h00;
    if (!reset) begin
      case (control)
        2'b00: register = r_gpr[2][7:0];
        2'b01: register = r_gpr[2][15:8];
        2'b10: register = r_gpr[2][23:16];
`ifdef DISPLAY_PC_EN
        2'b11: register = r_pc[9:2];
`else
        2'b11: register = r_gpr[2][31:24];
`endif
        default: register = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu against an instruction-level reference model
module tb_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] control = 2'b00;
  logic [7:0] register;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog  [64];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

`ifdef DISPLAY_PC_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 4;
`endif

  cpu #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset), .control(control), .register(register)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [5:0] f, input int rs, rt, rd, sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int word);
    return {6'h02, 26'(word)};
  endfunction

  // Architectural model: one instruction per call, no notion of pipeline timing.
  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    m_pc = 32'h0;
  endfunction

  function automatic void m_write(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endfunction

  function automatic void m_step();
    logic [31:0] w, a, b, sx, zx, p4, nxt, ea;
    w   = prog[m_pc[7:2]];
    a   = m_reg[w[25:21]];
    b   = m_reg[w[20:16]];
    sx  = {{16{w[15]}}, w[15:0]};
    zx  = {16'h0, w[15:0]};
    p4  = m_pc + 32'd4;
    nxt = p4;
    ea  = a + sx;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: m_write(w[15:11], a + b);
        6'h22: m_write(w[15:11], a - b);
        6'h24: m_write(w[15:11], a & b);
        6'h25: m_write(w[15:11], a | b);
        6'h2A: m_write(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: m_write(w[15:11], b << w[10:6]);
        default: ;
      endcase
      6'h08: m_write(w[20:16], a + sx);
      6'h0C: m_write(w[20:16], a & zx);
      6'h0D: m_write(w[20:16], a | zx);
      6'h0F: m_write(w[20:16], {w[15:0], 16'h0});
      6'h23: m_write(w[20:16], m_mem[ea[7:2]]);
      6'h2B: m_mem[ea[7:2]] = b;
      6'h04: if (a == b) nxt = p4 + (sx << 2);
      6'h05: if (a != b) nxt = p4 + (sx << 2);
      6'h02: nxt = {p4[31:28], w[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic load_and_start();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) dut.r_imem[i] = prog[i];
    m_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input int cycles);
    load_and_start();
    for (int i = 0; i < cycles; i++) m_step();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_mem_prog();
    clear_prog();
    prog[0] = enc_i(6'h0F, 0, 1, 16'hDEAD);
    prog[1] = enc_i(6'h0D, 1, 1, 16'hBEEF);
    prog[2] = enc_i(6'h2B, 0, 1, 16'h0004);
    prog[3] = enc_i(6'h23, 0, 2, 16'h0004);
    prog[4] = enc_i(6'h08, 2, 2, 16'h0001);
    prog[5] = enc_j(5);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      control = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (register !== 8'h00) begin
        $display("FAIL reset_display cycle=%0d ctrl=%0d: got %02h expected 00", i, control, register);
        errors++;
      end
    end
    clear_prog();
    load_and_start();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_pc = 32'(4 * k);
      checks++;
      if (dut.r_pc !== exp_pc) begin
        $display("FAIL pc_advance edge=%0d: got %08h expected %08h", k, dut.r_pc, exp_pc);
        errors++;
      end
    end
  endtask

  task automatic test_display_bytes();
    logic [31:0] sh;
    logic [7:0]  exp;
    clear_prog();
    prog[0] = enc_i(6'h08, 0, 2, 16'h1234);
    prog[4] = enc_j(4);
    load_and_start();
    m_step();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      control = 2'b00;
      #1;
      exp = (k >= 3) ? m_reg[2][7:0] : 8'h00;
      checks++;
      if (register !== exp) begin
        $display("FAIL addi_latency edge=%0d: got %02h expected %02h", k, register, exp);
        errors++;
      end
    end
    for (int c = 0; c < NBYTES; c++) begin
      control = 2'(c);
      #1;
      sh = m_reg[2] >> (8 * c);
      checks++;
      if (register !== sh[7:0]) begin
        $display("FAIL addi_bytes ctrl=%0d: got %02h expected %02h", c, register, sh[7:0]);
        errors++;
      end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] sh;
    clear_prog();
    prog[0] = enc_i(6'h08, 0, 1, 16'h0005);
    prog[1] = enc_r(6'h20, 1, 1, 2, 0);
    prog[2] = enc_j(2);
    run_prog(12);
    control = 2'b00;
    #1;
    sh = m_reg[2];
    checks++;
    if (register !== sh[7:0]) begin
      $display("FAIL fwd_display: got %02h expected %02h", register, sh[7:0]);
      errors++;
    end
    checks++;
    if (dut.r_gpr[2] !== 32'h0000000A) begin
      $display("FAIL fwd_v0: got %08h expected 0000000a", dut.r_gpr[2]);
      errors++;
    end
  endtask

  task automatic test_memory();
    logic [31:0] sh;
    fill_mem_prog();
    run_prog(16);
    for (int c = 0; c < NBYTES; c++) begin
      control = 2'(c);
      #1;
      sh = m_reg[2] >> (8 * c);
      checks++;
      if (register !== sh[7:0]) begin
        $display("FAIL mem_bytes ctrl=%0d: got %02h expected %02h", c, register, sh[7:0]);
        errors++;
      end
    end
    checks++;
    if (dut.r_gpr[2] !== 32'hDEADBEF0) begin
      $display("FAIL mem_v0: got %08h expected deadbef0", dut.r_gpr[2]);
      errors++;
    end
    checks++;
    if (dut.r_dmem[1] !== m_mem[1]) begin
      $display("FAIL mem_word1: got %08h expected %08h", dut.r_dmem[1], m_mem[1]);
      errors++;
    end
  endtask

  task automatic test_branch_skip();
    logic [31:0] sh;
    clear_prog();
    prog[0] = enc_i(6'h04, 0, 0, 16'h0001);
    prog[1] = enc_i(6'h08, 0, 2, 16'h0001);
    prog[2] = enc_i(6'h08, 0, 2, 16'h0007);
    prog[3] = enc_j(3);
    run_prog(12);
    for (int c = 0; c < NBYTES; c++) begin
      control = 2'(c);
      #1;
      sh = m_reg[2] >> (8 * c);
      checks++;
      if (register !== sh[7:0]) begin
        $display("FAIL beq_bytes ctrl=%0d: got %02h expected %02h", c, register, sh[7:0]);
        errors++;
      end
    end
    checks++;
    if (dut.r_gpr[2] !== 32'd7) begin
      $display("FAIL beq_v0: got %08h expected 00000007", dut.r_gpr[2]);
      errors++;
    end
  endtask

  task automatic test_loop();
    clear_prog();
    prog[0] = enc_i(6'h08, 0, 3, 16'h0003);
    prog[1] = enc_i(6'h08, 2, 2, 16'h0001);
    prog[2] = enc_i(6'h08, 3, 3, 16'hFFFF);
    prog[3] = enc_i(6'h05, 3, 0, 16'h0001);
    prog[4] = enc_j(6);
    prog[5] = enc_j(1);
    prog[6] = enc_j(6);
    run_prog(40);
    control = 2'b00;
    #1;
    checks++;
    if (register !== m_reg[2][7:0]) begin
      $display("FAIL loop_display: got %02h expected %02h", register, m_reg[2][7:0]);
      errors++;
    end
    checks++;
    if (dut.r_gpr[2] !== 32'd3) begin
      $display("FAIL loop_count: got %0d expected 3", dut.r_gpr[2]);
      errors++;
    end
    checks++;
    if (dut.r_gpr[3] !== m_reg[3]) begin
      $display("FAIL loop_counter: got %08h expected %08h", dut.r_gpr[3], m_reg[3]);
      errors++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] sh;
    fill_mem_prog();
    run_prog(16);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        control = 2'(c);
        #1;
        checks++;
        if (register !== 8'h00) begin
          $display("FAIL reset_after_run cyc=%0d ctrl=%0d: got %02h expected 00", i, c, register);
          errors++;
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (dut.r_gpr[2] !== 32'h0) begin
      $display("FAIL reset_midrun_v0: got %08h expected 00000000", dut.r_gpr[2]);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 16; i++) m_step();
    repeat (16) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NBYTES; c++) begin
      control = 2'(c);
      #1;
      sh = m_reg[2] >> (8 * c);
      checks++;
      if (register !== sh[7:0]) begin
        $display("FAIL rerun_bytes ctrl=%0d: got %02h expected %02h", c, register, sh[7:0]);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    logic [31:0] hist [N];
    logic [31:0] sh, imm;
    logic [5:0]  fsel [6];
    int kind, rs, rt, rd;
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24;
    fsel[3] = 6'h25; fsel[4] = 6'h2A; fsel[5] = 6'h00;
    for (int iter = 0; iter < 4; iter++) begin
      clear_prog();
      for (int i = 0; i < N; i++) begin
        kind = $urandom_range(0, 11);
        rs   = $urandom_range(0, 7);
        rt   = ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, 7);
        rd   = ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, 7);
        imm  = $urandom;
        case (kind)
          0, 1, 2: prog[i] = enc_r(fsel[$urandom_range(0, 5)], rs, $urandom_range(0, 7), rd, $urandom_range(0, 31));
          3: prog[i] = enc_i(6'h08, rs, rt, imm[15:0]);
          4: prog[i] = enc_i(6'h0C, rs, rt, imm[15:0]);
          5: prog[i] = enc_i(6'h0D, rs, rt, imm[15:0]);
          6: prog[i] = enc_i(6'h0F, 0, rt, imm[15:0]);
          7, 8: prog[i] = enc_i(6'h2B, rs, $urandom_range(0, 7), imm[15:0]);
          9, 10: prog[i] = enc_i(6'h23, rs, rt, imm[15:0]);
          default: prog[i] = (imm[16]) ? enc_i(6'h3F, rs, 2, imm[15:0]) : enc_r(6'h26, rs, rt, 2, 0);
        endcase
      end
      load_and_start();
      for (int i = 0; i < N; i++) begin
        m_step();
        hist[i] = m_reg[2];
      end
      for (int k = 1; k <= N + 2; k++) begin
        @(negedge clk);
        control = 2'($urandom_range(0, NBYTES - 1));
        #1;
        sh = (k >= 3) ? hist[k-3] : 32'h0;
        sh = sh >> (8 * control);
        checks++;
        if (register !== sh[7:0]) begin
          $display("FAIL rand_cycle iter=%0d edge=%0d ctrl=%0d: got %02h expected %02h", iter, k, control, register, sh[7:0]);
          errors++;
        end
      end
      for (int r = 1; r < 8; r++) begin
        checks++;
        if (dut.r_gpr[r] !== m_reg[r]) begin
          $display("FAIL rand_gpr iter=%0d r=%0d: got %08h expected %08h", iter, r, dut.r_gpr[r], m_reg[r]);
          errors++;
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_display_bytes();
    test_forwarding();
    test_memory();
    test_branch_skip();
    test_loop();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
